// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic DEPTH-stage pipeline register chain with valid/ready, flush and $0 writeback rule.
// Define PIPE_FWD_TAP_EN to add the combinational forwarding tap (fwd_addr/fwd_hit/fwd_data).
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 2,
    parameter int ADDR_W = 5,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_waddr,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_FWD_TAP_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);
    logic [DEPTH-1:0] valid_q, valid_d, wen_q, wen_d, adv;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][ADDR_W-1:0] waddr_q, waddr_d;
    logic [DEPTH:0] v_src, w_src;
    logic [DEPTH:0][DATA_W-1:0] d_src;
    logic [DEPTH:0][ADDR_W-1:0] a_src;
    logic accept;

    // A stage may advance if it is empty or everything downstream of it advances.
    always_comb begin : p_adv
        logic a;
        a = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            a = ~valid_q[i] | a;
            adv[i] = a;
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign accept   = in_valid & in_ready;

    // Source of stage i is stage i-1; stage 0 takes the input or a zeroed bubble.
    assign v_src = {valid_q, accept};
    assign w_src = {wen_q, accept & in_wen & (|in_waddr)};
    assign d_src = {data_q, accept ? in_data : {DATA_W{1'b0}}};
    assign a_src = {waddr_q, accept ? in_waddr : {ADDR_W{1'b0}}};

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        data_d  = data_q;
        waddr_d = waddr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i]) begin
                valid_d[i] = v_src[i];
                wen_d[i]   = w_src[i];
                data_d[i]  = d_src[i];
                waddr_d[i] = a_src[i];
            end
        end
        if (flush) begin
            valid_d = '0;
            wen_d   = '0;
            data_d  = '0;
            waddr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            wen_q   <= '0;
            data_q  <= '0;
            waddr_q <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            data_q  <= data_d;
            waddr_q <= waddr_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign out_wen   = wen_q[DEPTH-1] & out_valid;
    assign out_waddr = waddr_q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
    end

`ifdef PIPE_FWD_TAP_EN
    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && wen_q[i] && waddr_q[i] == fwd_addr && |fwd_addr && !flush) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[i];
            end
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: drives a DEPTH=2 and a DEPTH=3 chain with shared stimulus, scoreboard per instance.
// Forwarding-tap checks are compiled in when PIPE_FWD_TAP_EN is defined.
module tb_pipe_stage_chain;
    typedef struct packed {
        logic [31:0] d;
        logic        w;
        logic [4:0]  a;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, in_wen = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [4:0]  in_waddr = '0;
    logic        rdy[2], ov[2], ow[2];
    logic [31:0] od[2];
    logic [4:0]  oa[2];
    logic [1:0]  occ[2];
`ifdef PIPE_FWD_TAP_EN
    logic [4:0]  fwd_addr = '0;
    logic        fh[2];
    logic [31:0] fd[2];
`endif

    ent_t sb[2][$];
    int   dep[2] = '{2, 3};
    int   errors = 0, checks = 0, cyc = 0;
    int   nacc[2], nout[2], first_acc[2], first_out[2], last_out[2];

    always #5 clk = ~clk;

    pipe_stage_chain #(.DATA_W(32), .DEPTH(2), .ADDR_W(5)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .in_wen(in_wen), .in_waddr(in_waddr), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_wen(ow[0]), .out_waddr(oa[0]), .occupancy(occ[0])
`ifdef PIPE_FWD_TAP_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fh[0]), .fwd_data(fd[0])
`endif
    );

    pipe_stage_chain #(.DATA_W(32), .DEPTH(3), .ADDR_W(5)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .in_wen(in_wen), .in_waddr(in_waddr), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_wen(ow[1]), .out_waddr(oa[1]), .occupancy(occ[1])
`ifdef PIPE_FWD_TAP_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fh[1]), .fwd_data(fd[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] d, input logic w, input logic [4:0] a);
        in_valid = v;
        in_data  = d;
        in_wen   = w;
        in_waddr = a;
    endtask

    // One cycle: check outputs against the model, update scoreboards, then cross the edge.
    task automatic step();
        ent_t e;
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready d%0d", dep[k]), 64'(rdy[k]),
                64'(!flush && (sb[k].size() < dep[k] || out_ready)));
            chk($sformatf("occupancy d%0d", dep[k]), 64'(occ[k]), 64'(sb[k].size()));
            if (flush) chk($sformatf("out_valid flush d%0d", dep[k]), 64'(ov[k]), 64'(0));
            if (!ov[k]) chk($sformatf("out_wen idle d%0d", dep[k]), 64'(ow[k]), 64'(0));
            if (ov[k] && out_ready) begin
                if (sb[k].size() == 0) chk($sformatf("unexpected out d%0d", dep[k]), 64'(ov[k]), 64'(0));
                else begin
                    e = sb[k].pop_front();
                    chk($sformatf("out_data d%0d", dep[k]), 64'(od[k]), 64'(e.d));
                    chk($sformatf("out_wen d%0d", dep[k]), 64'(ow[k]), 64'(e.w));
                    chk($sformatf("out_waddr d%0d", dep[k]), 64'(oa[k]), 64'(e.a));
                    if (nout[k] == 0) first_out[k] = cyc;
                    last_out[k] = cyc;
                    nout[k]++;
                end
            end
            if (in_valid && rdy[k]) begin
                sb[k].push_back('{d: in_data, w: in_wen && in_waddr != 0, a: in_waddr});
                if (nacc[k] == 0) first_acc[k] = cyc;
                nacc[k]++;
            end
            if (flush) sb[k].delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        drv(1'b0, '0, 1'b0, '0);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && (sb[0].size() != 0 || sb[1].size() != 0); n++) step();
        chk("drain empty", 64'(sb[0].size() + sb[1].size()), 64'(0));
        step();
    endtask

    task automatic clr_stats();
        for (int k = 0; k < 2; k++) begin
            nacc[k] = 0;
            nout[k] = 0;
        end
    endtask

    initial begin
        clr_stats();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset out_valid", 64'(ov[k]), 64'(0));
            chk("reset occupancy", 64'(occ[k]), 64'(0));
            chk("reset out_data", 64'(od[k]), 64'(0));
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Streaming 1..8 at full throughput
        clr_stats();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 32'(i), i[0], 5'(i * 3));
            step();
        end
        drain();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("latency d%0d", dep[k]), 64'(first_out[k] - first_acc[k]), 64'(dep[k]));
            chk($sformatf("back-to-back d%0d", dep[k]), 64'(last_out[k] - first_out[k]), 64'(7));
            chk($sformatf("stream count d%0d", dep[k]), 64'(nout[k]), 64'(8));
        end

        // Backpressure: offer A,B,C,D with the sink stalled, then release while D is still offered
        out_ready = 1'b0;
        drv(1'b1, 32'hA, 1'b1, 5'd1); step();
        drv(1'b1, 32'hB, 1'b1, 5'd2); step();
        drv(1'b1, 32'hC, 1'b1, 5'd3); step();
        drv(1'b1, 32'hD, 1'b1, 5'd4);
        #1;
        chk("full occupancy d3", 64'(occ[1]), 64'(3));
        chk("full in_ready d3", 64'(rdy[1]), 64'(0));
        step();
        out_ready = 1'b1;
        step();
        drain();

        // Bubble collapse under stall
        out_ready = 1'b0;
        drv(1'b1, 32'h1, 1'b0, 5'd7); step();
        drv(1'b0, '0, 1'b0, '0); step();
        drv(1'b1, 32'h2, 1'b1, 5'd0); step();
        drv(1'b0, '0, 1'b0, '0);
        #1;
        chk("collapse occupancy d3", 64'(occ[1]), 64'(2));
        drain();

        // Flush with two in flight and a live input that must be dropped
        out_ready = 1'b0;
        drv(1'b1, 32'h55, 1'b1, 5'd9); step();
        drv(1'b1, 32'h66, 1'b1, 5'd10); step();
        out_ready = 1'b1;
        flush = 1'b1;
        drv(1'b1, 32'hDEAD, 1'b1, 5'd11);
        step();
        flush = 1'b0;
        drv(1'b0, '0, 1'b0, '0);
        #1;
        chk("post-flush out_data d3", 64'(od[1]), 64'(0));
        for (int n = 0; n < 4; n++) step();

`ifdef PIPE_FWD_TAP_EN
        out_ready = 1'b0;
        drv(1'b1, 32'h22, 1'b1, 5'd5); step();
        drv(1'b1, 32'h11, 1'b1, 5'd5); step();
        drv(1'b0, '0, 1'b0, '0);
        fwd_addr = 5'd5;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("fwd hit youngest", 64'(fh[k]), 64'(1));
            chk("fwd data youngest", 64'(fd[k]), 64'h11);
        end
        fwd_addr = 5'd7;
        #1;
        chk("fwd miss hit", 64'(fh[1]), 64'(0));
        chk("fwd miss data", 64'(fd[1]), 64'(0));
        fwd_addr = 5'd5;
        flush = 1'b1;
        #1;
        chk("fwd flush hit", 64'(fh[1]), 64'(0));
        step();
        flush = 1'b0;
        drv(1'b1, 32'h33, 1'b1, 5'd0); step();
        drv(1'b0, '0, 1'b0, '0);
        fwd_addr = 5'd0;
        #1;
        chk("fwd zero hit", 64'(fh[0]), 64'(0));
        chk("fwd zero data", 64'(fd[0]), 64'(0));
        drain();
`endif

        // Asynchronous reset with the DEPTH=3 chain full
        out_ready = 1'b0;
        drv(1'b1, 32'h71, 1'b1, 5'd1); step();
        drv(1'b1, 32'h72, 1'b1, 5'd2); step();
        drv(1'b1, 32'h73, 1'b1, 5'd3); step();
        drv(1'b0, '0, 1'b0, '0);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async reset out_valid", 64'(ov[k]), 64'(0));
            chk("async reset occupancy", 64'(occ[k]), 64'(0));
            chk("async reset out_data", 64'(od[k]), 64'(0));
            sb[k].delete();
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
